timer_ctrl: RTL
===============

# timer_ctrl

Sequencing controller for the countdown timer datapath in the multimode clock. It owns the user-facing preset registers (hours/minutes/seconds) and the set/run/pause/alarm state machine. It drives the timer's start/stop and load inputs and watches the timer's live count to detect expiry. Button inputs arrive already debounced and one-pulsed; outputs feed the timer core and the display/blink logic.

## Interface
- `ALARM_CYCLES`, default 100_000_000: clock cycles `alarm_o` stays high after expiry (1 s at 100 MHz); benches override it to a small value.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `btn_start` in 1: one-cycle pulse; start/pause/resume.
- `btn_mode` in 1: one-cycle pulse; step the field selection.
- `btn_inc` in 1: one-cycle pulse; increment the selected preset field.
- `btn_clear` in 1: one-cycle pulse; abort or clear.
- `hours_i` in 8: live timer count, binary.
- `minutes_i` in 8: live timer count, binary.
- `seconds_i` in 8: live timer count, binary.
- `milli_i` in 12: live timer count, binary.
- `run_o` out 1: timer Stop_Start enable.
- `load_o` out 1: one-cycle preset load strobe to the timer.
- `set_hours_o`, `set_minutes_o`, `set_seconds_o` out 8 each: preset registers.
- `field_sel_o` out 2: field selection; 0 none, 1 hours, 2 minutes, 3 seconds (drives display blink).
- `alarm_o` out 1: expiry indication.
- `state_o` out 3: current state encoding.

## Operation
- States, with `state_o` encoding: IDLE=0, SET_HR=1, SET_MIN=2, SET_SEC=3, LOAD=4, RUN=5, PAUSE=6, ALARM=7.
- Same-cycle button priority: clear > start > mode > inc. Only the highest-priority button is acted on.
- **IDLE**
  - `btn_mode` goes to SET_HR.
  - `btn_start` goes to LOAD if the preset is non-zero; otherwise stay in IDLE.
- **SET_HR / SET_MIN / SET_SEC**
  - `btn_inc` increments the selected field. Hours wrap 23→0; minutes and seconds wrap 59→0.
  - `btn_mode` advances SET_HR→SET_MIN→SET_SEC→IDLE.
  - `btn_start` goes to LOAD if the preset is non-zero, else IDLE.
- **LOAD**: exactly one cycle; `load_o`=1; unconditionally go to RUN.
- **RUN**
  - `run_o`=1.
  - `btn_start` goes to PAUSE.
  - Expiry goes to ALARM. Expiry means `hours_i`, `minutes_i`, `seconds_i` and `milli_i` are all zero.
  - Expiry detection is masked in the first RUN cycle after LOAD.
- **PAUSE**
  - `run_o`=0.
  - `btn_start` goes to RUN with no reload.
  - `btn_clear` goes to IDLE.
- **ALARM**
  - `alarm_o`=1 and `run_o`=0.
  - A counter runs for `ALARM_CYCLES` cycles, then the block returns to IDLE.
  - Any button pulse returns to IDLE early.
- **`btn_clear`**
  - From RUN, PAUSE, LOAD or ALARM: go to IDLE, presets retained.
  - From IDLE or SET_*: go to IDLE, all presets zeroed.
- **Output decode**
  - `field_sel_o` is 1/2/3 in SET_HR/SET_MIN/SET_SEC, otherwise 0.
  - `set_*_o` change only on `btn_inc` or clear.

## Timing
- All outputs are registered, or decoded directly from the state register; no combinational path from any input to any output.
- Reset values:
  - state = IDLE.
  - `run_o`, `load_o`, `alarm_o` = 0.
  - `set_*_o` = 0.
  - `field_sel_o` = 0.
  - `state_o` = 0.
  - Alarm counter = 0.
- **Start latency**: `btn_start` at edge N puts the block in LOAD during cycle N+1 (`load_o`=1), and RUN with `run_o`=1 from cycle N+2.
- **Timer load contract**: the timer captures presets on the edge ending the LOAD cycle, so the count is valid in the first RUN cycle.
- **Stop latency**: `run_o` falls one cycle after the `btn_start` that pauses, or one cycle after the expiry condition is sampled in RUN.
- **Alarm duration**: `alarm_o` is high for exactly `ALARM_CYCLES` cycles when no button is pressed.
- **Reset mid-operation**: reset in any state forces IDLE next cycle and zeroes presets.
- **Expiry during pause**: a zero count while in PAUSE is ignored.
- **Resume at zero**: resuming from PAUSE at zero count expires one cycle after entering RUN (the mask applies only after LOAD).
- **Boundary conditions**:
  - `btn_inc` in IDLE, LOAD, RUN, PAUSE or ALARM is ignored.
  - `btn_mode` in RUN, PAUSE or LOAD is ignored.
  - The preset-zero check uses the register values at the cycle `btn_start` is sampled.

## Structure
- Shared package `timer_pkg`:
  - State encoding constants.
  - Field-select encodings.
  - Limits: `HOURS_MAX`=23, `MIN_SEC_MAX`=59, `MILLI_MAX`=999.
- Sub-module `wrap_counter`: 8-bit up counter with parameter `MAX`, inputs `inc` and `clr`, and synchronous wrap MAX→0. Instantiate it three times, once for each preset field.
- Keep the FSM, expiry detect and alarm hold counter in `timer_ctrl`.

## Test plan
- **Reset**: hold reset 2 cycles → `state_o`=0, all outputs 0; a random button storm during reset leaves presets at 0.
- **Set and wrap**:
  - mode, then 25× inc → `set_hours_o`=1.
  - mode, then 60× inc → `set_minutes_o`=0.
  - mode, then 5× inc → `set_seconds_o`=5; `field_sel_o` tracks 1/2/3.
- **Start with preset 0:00:05**: `btn_start` → `load_o` high exactly 1 cycle, `run_o`=1 from the next cycle.
  - Model the count reaching all-zero → `run_o`=0 and `alarm_o`=1 for `ALARM_CYCLES`=8 cycles, then IDLE.
- **Pause/resume**: in RUN, `btn_start` → PAUSE with `run_o`=0; second `btn_start` → RUN with no `load_o` pulse.
  - Count forced to zero while paused → no alarm.
- **Zero preset and clear**:
  - `btn_start` with preset 0:00:00 → stays IDLE, `load_o` never asserted.
  - `btn_clear` in SET_MIN → presets zeroed.
  - `btn_clear` in RUN → IDLE with presets retained.
- **Simultaneous buttons**: `btn_clear`+`btn_start` in RUN → IDLE; `btn_mode`+`btn_inc` in SET_HR → SET_MIN, hours unchanged.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared encodings and field limits for the countdown-timer sequencing controller.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    SET_SEC = 3'd3,
    LOAD    = 3'd4,
    RUN     = 3'd5,
    PAUSE   = 3'd6,
    ALARM   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HR   = 2'd1,
    FIELD_MIN  = 2'd2,
    FIELD_SEC  = 2'd3
  } field_sel_t;

  localparam logic [7:0]  HOURS_MAX   = 8'd23;
  localparam logic [7:0]  MIN_SEC_MAX = 8'd59;
  localparam logic [11:0] MILLI_MAX   = 12'd999;

endpackage

// File: rtl/wrap_counter.sv
// 8-bit preset field: increments on inc, wraps MAX->0, cleared by clr or reset.
module wrap_counter #(
  parameter logic [7:0] MAX = 8'd59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= (count == MAX) ? '0 : count + 8'd1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Set/run/pause/alarm sequencer for the countdown timer; owns the preset
// registers, expiry detection and the alarm hold counter.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned ALARM_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_clear,
  input  logic [7:0]  hours_i,
  input  logic [7:0]  minutes_i,
  input  logic [7:0]  seconds_i,
  input  logic [11:0] milli_i,
  output logic        run_o,
  output logic        load_o,
  output logic [7:0]  set_hours_o,
  output logic [7:0]  set_minutes_o,
  output logic [7:0]  set_seconds_o,
  output logic [1:0]  field_sel_o,
  output logic        alarm_o,
  output logic [2:0]  state_o
);

  state_t      state, state_next;
  field_sel_t  field_sel;
  logic        inc_hr, inc_min, inc_sec, clr_presets;
  logic        load_mask;
  logic        expired, preset_nz, any_btn;
  logic [31:0] alarm_cnt;

  wrap_counter #(.MAX(HOURS_MAX)) u_hours (
    .clk(clk), .reset(reset), .inc(inc_hr), .clr(clr_presets), .count(set_hours_o)
  );
  wrap_counter #(.MAX(MIN_SEC_MAX)) u_minutes (
    .clk(clk), .reset(reset), .inc(inc_min), .clr(clr_presets), .count(set_minutes_o)
  );
  wrap_counter #(.MAX(MIN_SEC_MAX)) u_seconds (
    .clk(clk), .reset(reset), .inc(inc_sec), .clr(clr_presets), .count(set_seconds_o)
  );

  assign expired   = (hours_i == '0) && (minutes_i == '0) && (seconds_i == '0) && (milli_i == '0);
  assign preset_nz = (set_hours_o != '0) || (set_minutes_o != '0) || (set_seconds_o != '0);
  assign any_btn   = btn_start || btn_mode || btn_inc || btn_clear;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      load_mask <= 1'b0;
      alarm_cnt <= '0;
    end else begin
      state     <= state_next;
      // The timer only holds the new preset from the first RUN cycle onward.
      load_mask <= (state == LOAD);
      alarm_cnt <= (state == ALARM && state_next == ALARM) ? alarm_cnt + 32'd1 : '0;
    end
  end

  always_comb begin
    state_next  = state;
    inc_hr      = 1'b0;
    inc_min     = 1'b0;
    inc_sec     = 1'b0;
    clr_presets = 1'b0;
    case (state)
      IDLE: begin
        if (btn_clear) begin
          clr_presets = 1'b1;
        end else if (btn_start) begin
          if (preset_nz) state_next = LOAD;
        end else if (btn_mode) begin
          state_next = SET_HR;
        end
      end
      SET_HR, SET_MIN, SET_SEC: begin
        if (btn_clear) begin
          clr_presets = 1'b1;
          state_next  = IDLE;
        end else if (btn_start) begin
          state_next = preset_nz ? LOAD : IDLE;
        end else if (btn_mode) begin
          state_next = (state == SET_HR)  ? SET_MIN :
                       (state == SET_MIN) ? SET_SEC : IDLE;
        end else if (btn_inc) begin
          inc_hr  = (state == SET_HR);
          inc_min = (state == SET_MIN);
          inc_sec = (state == SET_SEC);
        end
      end
      LOAD:  state_next = btn_clear ? IDLE : RUN;
      RUN: begin
        if (btn_clear)                   state_next = IDLE;
        else if (btn_start)              state_next = PAUSE;
        else if (expired && !load_mask)  state_next = ALARM;
      end
      PAUSE: begin
        if (btn_clear)      state_next = IDLE;
        else if (btn_start) state_next = RUN;
      end
      ALARM: begin
        if (any_btn || alarm_cnt == ALARM_CYCLES - 1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    field_sel = FIELD_NONE;
    case (state)
      SET_HR:  field_sel = FIELD_HR;
      SET_MIN: field_sel = FIELD_MIN;
      SET_SEC: field_sel = FIELD_SEC;
      default: field_sel = FIELD_NONE;
    endcase
  end

  assign field_sel_o = field_sel;
  assign state_o     = state;
  assign run_o       = (state == RUN);
  assign load_o      = (state == LOAD);
  assign alarm_o     = (state == ALARM);

endmodule
